muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add / restoring-divide step per cycle through a shared 32-bit adder.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | 32 iteration steps, one bit per cycle
// FIX   | sign correction, HI/LO written, done pulsed
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      st;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic [31:0] d;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  logic        sgn, sa, sb, dz;
  logic [31:0] abs_rs, abs_rt;
  logic [31:0] add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic [31:0] r_sh;
  logic        take;
  logic        hi2_ci;
  logic [31:0] hi_neg;
  logic        m_c;
  logic [31:0] m_s;

  always_comb begin
    sgn    = ~op[0];
    sa     = sgn & rs_val[31];
    sb     = sgn & rt_val[31];
    abs_rs = sa ? (32'd0 - rs_val) : rs_val;
    abs_rt = sb ? (32'd0 - rt_val) : rt_val;
    dz     = op[1] & (rt_val == 32'd0);
  end

  // Shared iteration adder: multiply step, divide trial, or low-word negation in FIX.
  always_comb begin
    r_sh   = {acc_hi[30:0], acc_lo[31]};
    add_a  = acc_hi;
    add_b  = d;
    add_ci = 1'b0;
    if (st == FIX) begin
      add_a  = ~acc_lo;
      add_b  = 32'd0;
      add_ci = 1'b1;
    end else if (is_div) begin
      add_a  = r_sh;
      add_b  = ~d;
      add_ci = 1'b1;
    end
    {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
    take   = acc_hi[31] | add_co;
    m_c    = acc_lo[0] & add_co;
    m_s    = acc_lo[0] ? add_s : acc_hi;
    // Product negation carries from the low word; remainder negates on its own.
    hi2_ci = is_div ? 1'b1 : add_co;
    hi_neg = ~acc_hi + {31'd0, hi2_ci};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      d      <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st     <= CALC;
            busy   <= 1'b1;
            cnt    <= 5'd0;
            is_div <= op[1];
            acc_hi <= 32'd0;
            d      <= op[1] ? abs_rt : abs_rs;
            // Divide by zero keeps the raw dividend so the remainder lands as rs_val.
            acc_lo <= op[1] ? (dz ? rs_val : abs_rs) : abs_rt;
            neg_lo <= ~dz & (sa ^ sb);
            neg_hi <= ~dz & (op[1] ? sa : (sa ^ sb));
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc_hi <= take ? add_s : r_sh;
            acc_lo <= {acc_lo[30:0], take};
          end else begin
            acc_hi <= {m_c, m_s[31:1]};
            acc_lo <= {m_s[0], acc_lo[31:1]};
          end
          if (cnt == 5'd31) st <= FIX;
        end
        FIX: begin
          hi   <= neg_hi ? hi_neg : acc_hi;
          lo   <= neg_lo ? add_s : acc_lo;
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus hand-written
// sequences for mid-operation writes/starts, MTHI/MTLO and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one op and follows it to completion. inj_at injects a DIVU 9/3 start
  // and an MTHI 0xAAAA at that cycle; rst_at asserts reset at that cycle;
  // we_start raises hi_we together with the accepted start.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inj_at, input int rst_at, input bit we_start);
    logic [31:0] h0, l0;
    int lat, busy_n, dn;
    bit held, saw;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    if (we_start) begin hi_we = 1'b1; wdata = 32'h99; end
    h0 = hi; l0 = lo;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check({nm, "_busy_e0"}, {31'd0, busy}, 32'd1);
    lat = 0; busy_n = 1; held = 1'b1; saw = 1'b0;
    for (int k = 1; k <= 40 && !saw; k++) begin
      @(negedge clk);
      if (k == inj_at) begin
        start = 1'b1; op = DIVU; rs_val = 32'd9; rt_val = 32'd3;
        hi_we = 1'b1; wdata = 32'hAAAA;
      end
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; rst = 1'b0;
      if (k == rst_at) begin
        check({nm, "_rst_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_rst_done"}, {31'd0, done}, 32'd0);
        check({nm, "_rst_hi"}, hi, 32'd0);
        check({nm, "_rst_lo"}, lo, 32'd0);
        dn = 0;
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          if (done || busy) dn++;
        end
        check({nm, "_rst_no_done"}, dn, 32'd0);
        return;
      end
      if (done) begin
        saw = 1'b1;
        lat = k;
      end else begin
        if (busy) busy_n++;
        if (hi !== h0 || lo !== l0) held = 1'b0;
      end
    end
    check({nm, "_latency"}, lat, 32'd33);
    check({nm, "_busy_cycles"}, busy_n, 32'd33);
    check({nm, "_hilo_held"}, {31'd0, held}, 32'd1);
    check({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
    @(posedge clk); #1;
    check({nm, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({nm, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[7]  = '{DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[8]  = '{MULT,  32'd6,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFE2};
    vecs[9]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[10] = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[12] = '{MULT,  32'd0,        32'hDEADBEEF, 32'd0,        32'd0};

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].hi, vecs[i].lo, 0, 0, 1'b0);

    // start and MTHI while busy are both ignored
    run_op("busy_ignore", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 5, 0, 1'b0);

    // MTLO / MTHI while idle
    @(negedge clk); lo_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1 lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_no_done", {31'd0, done}, 32'd0);
    @(negedge clk); hi_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1 hi_we = 1'b0;
    check("mthi_hi", hi, 32'h55);
    check("mthi_lo_kept", lo, 32'h12345678);

    // start wins over a simultaneous MTHI
    run_op("start_vs_mthi", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0, 1'b1);

    // reset in the middle of a MULT, then a clean MULTU
    run_op("mid_reset", MULT, 32'hFFFFFFFD, 32'd7, 32'd0, 32'd0, 0, 10, 1'b0);
    run_op("after_reset", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
